// File: rtl/bus_sram_responder_if.sv
// Data-bus bundle between an initiator and the SRAM responder.
// The master drives address, write data, access type and length.
// The slave returns read data, the completion strobe and the IO-region flag.
interface bus_sram_responder_if;
  logic [31:0] db_addr;
  logic [31:0] db_dataIn;
  logic [1:0]  db_accessType;
  logic [1:0]  db_memLen;
  logic [31:0] db_dataOut;
  logic        db_ready;
  logic        db_io;

  modport master (
    output db_addr, db_dataIn, db_accessType, db_memLen,
    input  db_dataOut, db_ready, db_io
  );

  modport slave (
    input  db_addr, db_dataIn, db_accessType, db_memLen,
    output db_dataOut, db_ready, db_io
  );
endinterface

// File: rtl/bus_sram_responder.sv
// Word-organised SRAM behind a simple request/ready data bus.
// Each request is latched on acceptance and answered after LATENCY wait
// cycles with a one-cycle ready strobe. Addresses at or above IO_BASE form
// an IO window: reads there return zero and writes are dropped.
module bus_sram_responder #(
  parameter int          ADDR_BITS = 10,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] IO_BASE   = 32'hFFFF0000
) (
  input logic                 clk,
  input logic                 res,
  bus_sram_responder_if.slave bus
);

  localparam int         WORDS       = 1 << ADDR_BITS;
  localparam int         CNT_START_I = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [3:0] CNT_START   = CNT_START_I[3:0];

  localparam logic [1:0] TYPE_NONE = 2'd0;
  localparam logic [1:0] TYPE_W    = 2'd2;
  localparam logic [1:0] LEN_BYTE  = 2'd0;
  localparam logic [1:0] LEN_HALF  = 2'd1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  count;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  len_q;
  logic [1:0]  type_q;
  logic        ready_q;
  logic [31:0] data_out_q;

  logic [31:0] mem [0:WORDS-1];

  logic        accept;
  logic [31:0] req_addr;
  logic [1:0]  req_len;
  logic [1:0]  req_type;
  logic [31:0] rd_word;
  logic [31:0] rd_lanes;
  logic [3:0]  wr_be;
  logic [31:0] wr_word;
  logic        wr_en;

  assign bus.db_io      = (bus.db_addr >= IO_BASE);
  assign bus.db_ready   = ready_q;
  assign bus.db_dataOut = data_out_q;

  assign accept = (state == IDLE) && (bus.db_accessType != TYPE_NONE);

  // Next-state logic: accept in IDLE, count down or abort in WAIT, RESP lasts one cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (bus.db_accessType == TYPE_NONE) begin
          next_state = IDLE;
        end else if (count == 4'd0) begin
          next_state = RESP;
        end
      end
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Read path: in IDLE the live bus is used so a zero-latency request can be answered at once
  always_comb begin
    req_addr = (state == IDLE) ? bus.db_addr       : addr_q;
    req_len  = (state == IDLE) ? bus.db_memLen     : len_q;
    req_type = (state == IDLE) ? bus.db_accessType : type_q;
    rd_word  = mem[req_addr[ADDR_BITS+1:2]];
    rd_lanes = rd_word;
    case (req_len)
      LEN_BYTE: begin
        case (req_addr[1:0])
          2'd0:    rd_lanes = {24'd0, rd_word[7:0]};
          2'd1:    rd_lanes = {24'd0, rd_word[15:8]};
          2'd2:    rd_lanes = {24'd0, rd_word[23:16]};
          default: rd_lanes = {24'd0, rd_word[31:24]};
        endcase
      end
      LEN_HALF: begin
        rd_lanes = req_addr[1] ? {16'd0, rd_word[31:16]} : {16'd0, rd_word[15:0]};
      end
      default: rd_lanes = rd_word;
    endcase
    if (req_addr >= IO_BASE) begin
      rd_lanes = 32'd0;
    end
  end

  // Write path: byte enables and replicated data from the latched request, blocked by reset and IO
  always_comb begin
    wr_be   = 4'b1111;
    wr_word = data_q;
    case (len_q)
      LEN_BYTE: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_word = {4{data_q[7:0]}};
      end
      LEN_HALF: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{data_q[15:0]}};
      end
      default: ;
    endcase
    wr_en = (state == RESP) && (type_q == TYPE_W) && !(addr_q >= IO_BASE) && !res;
  end

  // RAM array: byte-enabled update on the edge that ends RESP; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[addr_q[ADDR_BITS+1:2]][8*i +: 8] <= wr_word[8*i +: 8];
        end
      end
    end
  end

  // Control and output registers: state, wait counter, request latches, ready and read data
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      count      <= 4'd0;
      ready_q    <= 1'b0;
      data_out_q <= 32'd0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state == RESP);
      if (accept) begin
        addr_q <= bus.db_addr;
        data_q <= bus.db_dataIn;
        len_q  <= bus.db_memLen;
        type_q <= bus.db_accessType;
        count  <= CNT_START;
      end else if ((state == WAIT) && (count != 4'd0)) begin
        count <= count - 4'd1;
      end
      if ((next_state == RESP) && (req_type != TYPE_W)) begin
        data_out_q <= rd_lanes;
      end
    end
  end

endmodule

// File: tb/tb_bus_sram_responder.sv
// Self-checking bench for bus_sram_responder.
// Two instances (LATENCY 2 and LATENCY 0) are driven transaction by transaction.
// A transaction-level model (word array plus expected ready cycle) is compared
// against both instances on every falling edge.
module tb_bus_sram_responder;

  localparam int          NDUT    = 2;
  localparam int          AB      = 10;
  localparam int          WORDS   = 1 << AB;
  localparam logic [31:0] IO_BASE = 32'hFFFF0000;
  localparam logic [1:0]  T_NONE  = 2'd0;
  localparam logic [1:0]  T_R     = 2'd1;
  localparam logic [1:0]  T_W     = 2'd2;
  localparam logic [1:0]  T_X     = 2'd3;

  logic            clk = 1'b0;
  logic [NDUT-1:0] res_drv;
  logic [31:0]     addr_drv [NDUT];
  logic [31:0]     data_drv [NDUT];
  logic [1:0]      type_drv [NDUT];
  logic [1:0]      len_drv  [NDUT];
  logic [NDUT-1:0] ready_mon;
  logic [NDUT-1:0] io_mon;
  logic [31:0]     out_mon  [NDUT];

  int              cyc = 0;
  logic [NDUT-1:0] last_res = '1;
  int              pend_cyc  [NDUT];
  logic            pend_read [NDUT];
  logic [31:0]     pend_data [NDUT];
  logic [31:0]     prev_out  [NDUT];
  logic [31:0]     model_mem [NDUT][WORDS];
  logic            cmp_exp_ready;
  int              assert_count = 0;
  int              fail_count = 0;

  bus_sram_responder_if bus_lat2 ();
  bus_sram_responder_if bus_lat0 ();

  assign bus_lat2.db_addr       = addr_drv[0];
  assign bus_lat2.db_dataIn     = data_drv[0];
  assign bus_lat2.db_accessType = type_drv[0];
  assign bus_lat2.db_memLen     = len_drv[0];
  assign ready_mon[0]           = bus_lat2.db_ready;
  assign io_mon[0]              = bus_lat2.db_io;
  assign out_mon[0]             = bus_lat2.db_dataOut;

  assign bus_lat0.db_addr       = addr_drv[1];
  assign bus_lat0.db_dataIn     = data_drv[1];
  assign bus_lat0.db_accessType = type_drv[1];
  assign bus_lat0.db_memLen     = len_drv[1];
  assign ready_mon[1]           = bus_lat0.db_ready;
  assign io_mon[1]              = bus_lat0.db_io;
  assign out_mon[1]             = bus_lat0.db_dataOut;

  bus_sram_responder #(.ADDR_BITS(AB), .LATENCY(2), .IO_BASE(IO_BASE)) dut_lat2 (
    .clk (clk),
    .res (res_drv[0]),
    .bus (bus_lat2)
  );

  bus_sram_responder #(.ADDR_BITS(AB), .LATENCY(0), .IO_BASE(IO_BASE)) dut_lat0 (
    .clk (clk),
    .res (res_drv[1]),
    .bus (bus_lat0)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter and record of whether reset was applied at the latest edge
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    last_res <= res_drv;
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int word_index(input logic [31:0] a);
    return int'((a >> 2) & 32'(WORDS - 1));
  endfunction

  // Model read: lane extraction by shifting, IO window reads as zero
  function automatic logic [31:0] model_read(input int k, input logic [31:0] a, input logic [1:0] len);
    logic [31:0] w;
    if (a >= IO_BASE) return 32'd0;
    w = model_mem[k][word_index(a)];
    if (len == 2'd0) return (w >> (8 * (a % 4))) & 32'h0000_00FF;
    if (len == 2'd1) return (w >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
    return w;
  endfunction

  // Model write: masked merge of shifted data, IO window writes are dropped
  function automatic void model_write(input int k, input logic [31:0] a, input logic [1:0] len,
                                      input logic [31:0] d);
    logic [31:0] mask;
    logic [31:0] val;
    if (a >= IO_BASE) return;
    if (len == 2'd0) begin
      mask = 32'h0000_00FF << (8 * (a % 4));
      val  = d << (8 * (a % 4));
    end else if (len == 2'd1) begin
      mask = 32'h0000_FFFF << (16 * ((a / 2) % 2));
      val  = d << (16 * ((a / 2) % 2));
    end else begin
      mask = 32'hFFFF_FFFF;
      val  = d;
    end
    model_mem[k][word_index(a)] = (model_mem[k][word_index(a)] & ~mask) | (val & mask);
  endfunction

  task automatic check_output(input string name, input int k, input logic [31:0] got,
                              input logic [31:0] want);
    assert_count++;
    if (got !== want) begin
      fail_count++;
      $display("[TB] FAIL %s (dut %0d, cycle %0d): got %h, expected %h", name, k, cyc, got, want);
    end
  endtask

  // Every falling edge: compare io flag, ready timing, read data and data hold against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < NDUT; k++) begin
        check_output("io_flag", k, {31'd0, io_mon[k]}, {31'd0, (addr_drv[k] >= IO_BASE)});
        if (last_res[k]) begin
          check_output("reset_ready", k, {31'd0, ready_mon[k]}, 32'd0);
          check_output("reset_data_out", k, out_mon[k], 32'd0);
        end else begin
          cmp_exp_ready = (pend_cyc[k] == cyc);
          check_output("ready", k, {31'd0, ready_mon[k]}, {31'd0, cmp_exp_ready});
          if (cmp_exp_ready && pend_read[k]) begin
            check_output("read_data", k, out_mon[k], pend_data[k]);
          end else if (!cmp_exp_ready) begin
            check_output("data_hold", k, out_mon[k], prev_out[k]);
          end
        end
        prev_out[k] = out_mon[k];
      end
    end
  end

  // Present a request and register its expected outcome once the accepting edge has passed
  task automatic start_req(input int k, input bit sync, input logic [1:0] typ, input logic [31:0] a,
                           input logic [1:0] len, input logic [31:0] d, output int acc);
    if (sync) begin
      @(negedge clk);
      #1;
    end
    type_drv[k] = typ;
    addr_drv[k] = a;
    len_drv[k]  = len;
    data_drv[k] = d;
    @(posedge clk);
    #1;
    acc          = cyc;
    pend_read[k] = (typ != T_W);
    pend_data[k] = model_read(k, a, len);
    pend_cyc[k]  = acc + lat_of(k);
  endtask

  // Full transaction: hold the request until ready is sampled (bounded), then release
  task automatic apply_stimulus(input int k, input bit sync, input logic [1:0] typ, input logic [31:0] a,
                                input logic [1:0] len, input logic [31:0] d,
                                output int lat, output logic [31:0] rd);
    int acc;
    bit seen;
    seen = 1'b0;
    lat  = -1;
    rd   = 32'd0;
    start_req(k, sync, typ, a, len, d, acc);
    for (int i = 0; (i < lat_of(k) + 4) && !seen; i++) begin
      @(negedge clk);
      if (ready_mon[k]) begin
        seen = 1'b1;
        lat  = cyc - acc + 1;
        rd   = out_mon[k];
      end
    end
    #1;
    type_drv[k] = T_NONE;
    pend_cyc[k] = -1;
    if (typ == T_W) model_write(k, a, len, d);
  endtask

  // Withdraw a request while it waits: w extra wait cycles before dropping the type
  task automatic abort_req(input int k, input logic [1:0] typ, input logic [31:0] a,
                           input logic [1:0] len, input logic [31:0] d, input int w);
    int acc;
    start_req(k, 1'b1, typ, a, len, d, acc);
    repeat (w) @(negedge clk);
    @(negedge clk);
    #1;
    type_drv[k] = T_NONE;
    pend_cyc[k] = -1;
    repeat (2) @(negedge clk);
  endtask

  // Assert reset w cycles into a request (w = latency hits the RESP cycle) for two edges
  task automatic reset_mid_op(input int k, input logic [1:0] typ, input logic [31:0] a,
                              input logic [1:0] len, input logic [31:0] d, input int w);
    int acc;
    start_req(k, 1'b1, typ, a, len, d, acc);
    repeat (w) @(negedge clk);
    @(negedge clk);
    #1;
    res_drv[k]  = 1'b1;
    pend_cyc[k] = -1;
    @(negedge clk);
    check_output("reset_ready_lit", k, {31'd0, ready_mon[k]}, 32'd0);
    check_output("reset_data_out_lit", k, out_mon[k], 32'd0);
    @(negedge clk);
    #1;
    res_drv[k]  = 1'b0;
    type_drv[k] = T_NONE;
  endtask

  // Drive an address with no access and check the IO flag combinationally
  task automatic probe_io(input int k, input logic [31:0] a, input logic want);
    @(negedge clk);
    #1;
    addr_drv[k] = a;
    #1;
    check_output("io_probe", k, {31'd0, io_mon[k]}, {31'd0, want});
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Directed scenarios followed by randomized traffic on both instances
  initial begin
    int          lat;
    logic [31:0] rd;
    logic [1:0]  typ;
    logic [1:0]  len;
    logic [31:0] a;
    logic [31:0] d;
    int          r;

    for (int k = 0; k < NDUT; k++) begin
      res_drv[k]   = 1'b1;
      addr_drv[k]  = 32'd0;
      data_drv[k]  = 32'd0;
      type_drv[k]  = T_NONE;
      len_drv[k]   = 2'd0;
      pend_cyc[k]  = -1;
      pend_read[k] = 1'b0;
      pend_data[k] = 32'd0;
      prev_out[k]  = 32'd0;
    end
    repeat (3) @(negedge clk);
    #1;
    res_drv = '0;

    // Basic write then read, first request on the first edge out of reset
    apply_stimulus(0, 1'b0, T_W, 32'h10, 2'd2, 32'hDEADBEEF, lat, rd);
    check_output("w_latency", 0, 32'(lat), 32'd3);
    apply_stimulus(0, 1'b1, T_R, 32'h10, 2'd2, 32'd0, lat, rd);
    check_output("r_latency", 0, 32'(lat), 32'd3);
    check_output("r_word_10", 0, rd, 32'hDEADBEEF);

    // Byte and half lanes
    apply_stimulus(0, 1'b1, T_W, 32'h20, 2'd2, 32'h11223344, lat, rd);
    apply_stimulus(0, 1'b1, T_W, 32'h23, 2'd0, 32'h000000AA, lat, rd);
    apply_stimulus(0, 1'b1, T_R, 32'h20, 2'd2, 32'd0, lat, rd);
    check_output("r_word_20", 0, rd, 32'hAA223344);
    apply_stimulus(0, 1'b1, T_R, 32'h22, 2'd1, 32'd0, lat, rd);
    check_output("r_half_22", 0, rd, 32'h0000AA22);
    apply_stimulus(0, 1'b1, T_X, 32'h21, 2'd0, 32'd0, lat, rd);
    check_output("r_byte_21", 0, rd, 32'h00000033);

    // Aborts of a read and of a write
    apply_stimulus(0, 1'b1, T_W, 32'h40, 2'd2, 32'h0BADF00D, lat, rd);
    abort_req(0, T_R, 32'h40, 2'd2, 32'd0, 0);
    apply_stimulus(0, 1'b1, T_W, 32'h40, 2'd2, 32'h600DCAFE, lat, rd);
    check_output("w_after_abort_latency", 0, 32'(lat), 32'd3);
    abort_req(0, T_W, 32'h40, 2'd2, 32'h11111111, 1);
    apply_stimulus(0, 1'b1, T_R, 32'h40, 2'd2, 32'd0, lat, rd);
    check_output("r_after_abort", 0, rd, 32'h600DCAFE);

    // IO window
    apply_stimulus(0, 1'b1, T_W, 32'h4, 2'd2, 32'hCAFE0001, lat, rd);
    probe_io(0, 32'hFFFEFFFC, 1'b0);
    probe_io(0, 32'hFFFF0000, 1'b1);
    apply_stimulus(0, 1'b1, T_W, 32'hFFFF0004, 2'd2, 32'h12345678, lat, rd);
    check_output("io_w_latency", 0, 32'(lat), 32'd3);
    check_output("io_flag_lit", 0, {31'd0, io_mon[0]}, 32'd1);
    apply_stimulus(0, 1'b1, T_R, 32'hFFFF0004, 2'd2, 32'd0, lat, rd);
    check_output("io_r_latency", 0, 32'(lat), 32'd3);
    check_output("io_r_data", 0, rd, 32'h00000000);
    apply_stimulus(0, 1'b1, T_R, 32'h4, 2'd2, 32'd0, lat, rd);
    check_output("ram_word1_kept", 0, rd, 32'hCAFE0001);

    // Reset in the middle of a write
    apply_stimulus(0, 1'b1, T_W, 32'h8, 2'd2, 32'hA5A5A5A5, lat, rd);
    apply_stimulus(0, 1'b1, T_R, 32'h8, 2'd2, 32'd0, lat, rd);
    reset_mid_op(0, T_W, 32'h8, 2'd2, 32'h12345678, 1);
    apply_stimulus(0, 1'b0, T_R, 32'h8, 2'd2, 32'd0, lat, rd);
    check_output("r_after_reset", 0, rd, 32'hA5A5A5A5);

    // Zero latency and address aliasing
    apply_stimulus(1, 1'b1, T_W, 32'h1000, 2'd2, 32'h00000005, lat, rd);
    check_output("lat0_w_latency", 1, 32'(lat), 32'd1);
    apply_stimulus(1, 1'b1, T_R, 32'h0, 2'd2, 32'd0, lat, rd);
    check_output("lat0_r_latency", 1, 32'(lat), 32'd1);
    check_output("alias_read", 1, rd, 32'h00000005);
    reset_mid_op(1, T_W, 32'h0, 2'd2, 32'h00000077, 0);
    apply_stimulus(1, 1'b0, T_R, 32'h0, 2'd2, 32'd0, lat, rd);
    check_output("lat0_reset_in_resp", 1, rd, 32'h00000005);

    // Randomized traffic over a small word pool, its aliases, the IO window and its lower boundary
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 16; i++) begin
        apply_stimulus(k, 1'b1, T_W, 32'(i * 4), 2'd2, $urandom, lat, rd);
      end
      apply_stimulus(k, 1'b1, T_W, 32'hFFFEFFFC, 2'd2, $urandom, lat, rd);
      for (int n = 0; n < 150; n++) begin
        typ = 2'($urandom_range(1, 3));
        len = 2'($urandom_range(0, 3));
        d   = $urandom;
        case ($urandom_range(0, 7))
          0:       a = IO_BASE + 32'($urandom_range(0, 15));
          1:       a = 32'hFFFEFFFC + 32'($urandom_range(0, 3));
          default: a = (32'($urandom_range(0, 3)) << 12) | 32'($urandom_range(0, 63));
        endcase
        r = $urandom_range(0, 9);
        if ((r == 0) && (lat_of(k) > 0)) begin
          abort_req(k, typ, a, len, d, $urandom_range(0, lat_of(k) - 1));
        end else if (r == 1) begin
          reset_mid_op(k, typ, a, len, d, $urandom_range(0, lat_of(k)));
        end else begin
          apply_stimulus(k, 1'b1, typ, a, len, d, lat, rd);
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
